// File: rtl/flex_timer_pkg.sv
// Shared types and defaults for the flex_timer counting primitive.
package flex_timer_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } timer_mode_t;

  localparam int DEFAULT_CNT_BITS      = 8;
  localparam int DEFAULT_PRESCALE_BITS = 4;

endpackage

// File: rtl/flex_prescaler.sv
// Divides enabled cycles into ticks: one tick every prescale_val+1 enabled cycles.
module flex_prescaler
  import flex_timer_pkg::*;
#(
  parameter int PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  output logic                     tick
);

  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};

  logic [PRESCALE_BITS-1:0] presc_r;

  assign tick = enable && (presc_r == prescale_val);

  // Phase counter; holds while disabled so the phase resumes where it stopped
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      presc_r <= '0;
    end else if (clear) begin
      presc_r <= '0;
    end else if (tick) begin
      presc_r <= '0;
    end else if (enable) begin
      presc_r <= presc_r + PRE_ONE;
    end else begin
      presc_r <= presc_r;
    end
  end

endmodule

// File: rtl/flex_timer.sv
// Up/down timer with prescaler, synchronous load and wrap/saturate/one-shot terminal modes.
module flex_timer
  import flex_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS  = DEFAULT_CNT_BITS,
  parameter int PRESCALE_BITS = DEFAULT_PRESCALE_BITS
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     dir_down,
  input  logic [1:0]               mode,
  input  logic [PRESCALE_BITS-1:0] prescale_val,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     wrap_pulse,
  output logic                     done
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] cnt_r;
  logic                    flag_r;
  logic                    wrap_r;
  logic                    done_r;

  logic [NUM_CNT_BITS-1:0] cnt_nxt_s;
  logic                    flag_nxt_s;
  logic                    wrap_nxt_s;
  logic                    done_nxt_s;
  logic [NUM_CNT_BITS-1:0] terminal_s;
  logic                    presc_en_s;
  logic                    tick_s;

  // A finished one-shot freezes the prescaler so no further ticks occur
  assign presc_en_s = count_enable && !((mode == MODE_ONESHOT) && done_r);
  assign terminal_s = dir_down ? {NUM_CNT_BITS{1'b0}} : rollover_val;

  flex_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (clear | load),
    .enable      (presc_en_s),
    .prescale_val(prescale_val),
    .tick        (tick_s)
  );

  // Next-state selection: clear > load > tick > hold
  always_comb begin
    cnt_nxt_s  = cnt_r;
    done_nxt_s = done_r;
    wrap_nxt_s = 1'b0;
    if (clear) begin
      cnt_nxt_s  = '0;
      done_nxt_s = 1'b0;
    end else if (load) begin
      cnt_nxt_s  = load_val;
      done_nxt_s = 1'b0;
    end else if (tick_s) begin
      if (cnt_r != terminal_s) begin
        cnt_nxt_s = dir_down ? (cnt_r - CNT_ONE) : (cnt_r + CNT_ONE);
      end else begin
        case (mode)
          MODE_SAT:     cnt_nxt_s  = cnt_r;
          MODE_ONESHOT: done_nxt_s = 1'b1;
          default: begin
            cnt_nxt_s  = dir_down ? rollover_val : {NUM_CNT_BITS{1'b0}};
            wrap_nxt_s = 1'b1;
          end
        endcase
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
    // After clear the flag reflects only the direction, not the compare
    if (clear) begin
      flag_nxt_s = dir_down;
    end else begin
      flag_nxt_s = (cnt_nxt_s == terminal_s);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r  <= '0;
      flag_r <= 1'b0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      flag_r <= flag_nxt_s;
      wrap_r <= wrap_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign count_out     = cnt_r;
  assign rollover_flag = flag_r;
  assign wrap_pulse    = wrap_r;
  assign done          = done_r;

endmodule

// File: tb/tb_flex_timer.sv
// Directed self-checking bench for flex_timer with hand-computed expectations.
module tb_flex_timer;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       count_enable;
  logic       load;
  logic [7:0] load_val;
  logic       dir_down;
  logic [1:0] mode;
  logic [3:0] prescale_val;
  logic [7:0] rollover_val;
  logic [7:0] count_out;
  logic       rollover_flag;
  logic       wrap_pulse;
  logic       done;

  int n_cmp;
  int n_err;

  flex_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .load         (load),
    .load_val     (load_val),
    .dir_down     (dir_down),
    .mode         (mode),
    .prescale_val (prescale_val),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] c, input logic f,
                           input logic w, input logic d);
    check({tag, ".count"}, {24'd0, count_out}, {24'd0, c});
    check({tag, ".flag"},  {31'd0, rollover_flag}, {31'd0, f});
    check({tag, ".wrap"},  {31'd0, wrap_pulse}, {31'd0, w});
    check({tag, ".done"},  {31'd0, done}, {31'd0, d});
  endtask

  logic [7:0] exp_cnt;
  int         pulses;
  logic [7:0] sat_seq [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_rst = 1'b0;
    clear = 1'b0;
    count_enable = 1'b0;
    load = 1'b0;
    load_val = 8'd0;
    dir_down = 1'b0;
    mode = 2'b00;
    prescale_val = 4'd0;
    rollover_val = 8'd5;

    #12;
    check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    n_rst = 1'b1;

    // Up / wrap, rollover 5, prescale 0
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check_all("wrap.clear", 8'd0, 1'b0, 1'b0, 1'b0);
    count_enable = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cyc(1);
      check_all($sformatf("wrap.c%0d", i), 8'(i % 6), (i % 6) == 5, i == 6, 1'b0);
    end
    count_enable = 1'b0;

    // Prescale 3: one increment per 4 enabled cycles, phase kept across a pause
    prescale_val = 4'd3;
    rollover_val = 8'd255;
    load_val = 8'd0;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    count_enable = 1'b1;
    cyc(3);
    check("pre.before_tick", {24'd0, count_out}, 32'd0);
    cyc(1);
    check("pre.first_tick", {24'd0, count_out}, 32'd1);
    cyc(2);
    count_enable = 1'b0;
    cyc(5);
    check("pre.paused", {24'd0, count_out}, 32'd1);
    count_enable = 1'b1;
    cyc(1);
    check("pre.resume_hold", {24'd0, count_out}, 32'd1);
    cyc(1);
    check("pre.resume_tick", {24'd0, count_out}, 32'd2);
    count_enable = 1'b0;

    // Down / saturate from 3
    prescale_val = 4'd0;
    dir_down = 1'b1;
    mode = 2'b01;
    load_val = 8'd3;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check_all("sat.load", 8'd3, 1'b0, 1'b0, 1'b0);
    sat_seq = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    count_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check_all($sformatf("sat.c%0d", i), sat_seq[i], sat_seq[i] == 8'd0, 1'b0, 1'b0);
    end
    count_enable = 1'b0;

    // One-shot, rollover 2, prescale 1
    dir_down = 1'b0;
    mode = 2'b10;
    rollover_val = 8'd2;
    prescale_val = 4'd1;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check_all("os.clear", 8'd0, 1'b0, 1'b0, 1'b0);
    count_enable = 1'b1;
    cyc(2);
    check_all("os.c1", 8'd1, 1'b0, 1'b0, 1'b0);
    cyc(2);
    check_all("os.c2", 8'd2, 1'b1, 1'b0, 1'b0);
    cyc(2);
    check_all("os.done", 8'd2, 1'b1, 1'b0, 1'b1);
    cyc(10);
    check_all("os.frozen", 8'd2, 1'b1, 1'b0, 1'b1);
    load_val = 8'd0;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check_all("os.reload", 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(2);
    check_all("os.restart", 8'd1, 1'b0, 1'b0, 1'b0);
    count_enable = 1'b0;

    // Priority: clear > load > tick
    mode = 2'b00;
    rollover_val = 8'd255;
    prescale_val = 4'd0;
    load_val = 8'd50;
    load = 1'b1;
    cyc(1);
    check("prio.load50", {24'd0, count_out}, 32'd50);
    clear = 1'b1;
    load_val = 8'd77;
    count_enable = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("prio.clear_wins", {24'd0, count_out}, 32'd0);
    cyc(1);
    check("prio.load_over_tick", {24'd0, count_out}, 32'd77);
    load = 1'b0;
    prescale_val = 4'd2;
    cyc(1);
    check("prio.presc_run", {24'd0, count_out}, 32'd77);
    load_val = 8'd90;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("prio.load90", {24'd0, count_out}, 32'd90);
    cyc(2);
    check("prio.presc_reset", {24'd0, count_out}, 32'd90);
    cyc(1);
    check("prio.after_reset_tick", {24'd0, count_out}, 32'd91);
    count_enable = 1'b0;

    // Boundary: start above rollover_val, overflow through 255 then wrap at 10
    prescale_val = 4'd0;
    rollover_val = 8'd10;
    load_val = 8'd200;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    exp_cnt = 8'd200;
    pulses = 0;
    count_enable = 1'b1;
    for (int i = 0; i < 67; i++) begin
      cyc(1);
      exp_cnt = (exp_cnt == 8'd10) ? 8'd0 : exp_cnt + 8'd1;
      check($sformatf("bnd.c%0d", i), {24'd0, count_out}, {24'd0, exp_cnt});
      if (wrap_pulse) pulses++;
      else pulses = pulses;
    end
    check("bnd.end_zero", {24'd0, count_out}, 32'd0);
    check("bnd.pulses", pulses, 32'd1);

    // rollover_val 0 counting up: stuck at 0 with a pulse every tick
    rollover_val = 8'd0;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check_all("zero.clear", 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    check_all("zero.t1", 8'd0, 1'b1, 1'b1, 1'b0);
    cyc(1);
    check_all("zero.t2", 8'd0, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset mid-count
    rollover_val = 8'd20;
    cyc(10);
    check_all("ares.pre", 8'd10, 1'b0, 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    check_all("ares.now", 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);
    n_rst = 1'b1;
    count_enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flex_timer.md
Name: flex_timer

Overview:
- Parametrised up/down timer/counter with a built-in prescaler, synchronous load and three terminal modes: wrap, saturate, one-shot.
- Outputs a level terminal flag, a single-cycle wrap pulse and a sticky done flag.
- Serves as the general timing primitive for bit-period, timeout and packet-length counting across the design.

Parameters:
- NUM_CNT_BITS, 8, width of the main count, rollover_val and load_val.
- PRESCALE_BITS, 4, width of the prescaler count and prescale_val.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of all state.
- count_enable  input  1  advances the prescaler while high.
- load  input  1  synchronous load of load_val.
- load_val  input  NUM_CNT_BITS  value loaded into count_out.
- dir_down  input  1  0 = count up, 1 = count down.
- mode  input  2  terminal mode: 00 wrap, 01 saturate, 10 one-shot, 11 reserved (treated as wrap).
- prescale_val  input  PRESCALE_BITS  a tick occurs every prescale_val+1 enabled cycles.
- rollover_val  input  NUM_CNT_BITS  terminal value when counting up; reload value when counting down.
- count_out  output  NUM_CNT_BITS  current count.
- rollover_flag  output  1  level; high while count_out equals the active terminal.
- wrap_pulse  output  1  high for one cycle after a wrap event.
- done  output  1  sticky one-shot completion flag.

Behaviour:
- Reset (n_rst=0, asynchronous): count_out=0, prescaler=0, rollover_flag=0, wrap_pulse=0, done=0.
- Priority, per rising edge: clear > load > tick > hold.
- clear: count_out=0, prescaler=0, wrap_pulse=0, done=0. rollover_flag=1 only if dir_down=1 (terminal is 0), else 0.
- load: count_out=load_val, prescaler=0, done=0, wrap_pulse=0. rollover_flag is recomputed from load_val against the current terminal.
- Prescaler:
  - Counts 0..prescale_val while count_enable=1 and not (mode=one-shot and done=1).
  - A tick is the cycle in which prescaler==prescale_val and the prescaler is enabled; the prescaler then returns to 0.
  - prescale_val=0 gives a tick on every enabled cycle. With count_enable=0, both prescaler and count hold.
- Active terminal: rollover_val when counting up; 0 when counting down.
- On a tick with count_out != terminal:
  - Up: count_out+1, modulo 2^NUM_CNT_BITS. A count above rollover_val runs through the natural overflow to 0 with no wrap_pulse.
  - Down: count_out-1.
- On a tick with count_out == terminal:
  - wrap: up reloads 0, down reloads rollover_val; wrap_pulse=1 next cycle.
  - saturate: count holds, no pulse.
  - one-shot: count holds, done<=1; later ticks are ignored until clear or load.
- rollover_flag is registered: it equals (next count_out == next terminal) and is updated every cycle, so it tracks changes to dir_down and rollover_val within one cycle.
- wrap_pulse is registered and is 0 on every cycle that is not directly after a wrap tick.
- dir_down and mode are sampled on each tick; a change mid-count takes effect at the next tick with no state flush.
- rollover_val=0 counting up in wrap mode: count stays 0, rollover_flag=1, wrap_pulse on every tick.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Decomposition:
- Package flex_timer_pkg:
  - enum timer_mode_t {MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10}.
  - Constants DEFAULT_CNT_BITS=8, DEFAULT_PRESCALE_BITS=4.
- Sub-module flex_prescaler (PRESCALE_BITS): ports clk, n_rst, clear, enable, prescale_val, tick. Its clear is driven by (clear | load).
- Top level holds the count datapath and flag registers.

Test Plan:
- Up/wrap: rollover_val=5, prescale_val=0, enable held. Required: count 0,1,2,3,4,5,0; rollover_flag high exactly while count=5; wrap_pulse high one cycle, aligned with the return to 0.
- Prescale: prescale_val=3, up, rollover_val=255. Required: count increments once per 4 enabled cycles. Drop count_enable for 5 cycles mid-period: prescaler and count hold, then resume at the same phase.
- Down/saturate: load_val=3, dir_down=1, mode=01. Required: count 3,2,1,0,0,0; rollover_flag=1 from count 0 onward; wrap_pulse never asserted.
- One-shot: up, rollover_val=2, prescale_val=1. Required: count reaches 2; the next tick sets done=1 with the count held. A further 10 cycles give no change. load_val=0 then clears done and counting restarts.
- Priority: clear, load and a tick in the same cycle give count_out=0. Load and a tick in the same cycle give count_out=load_val, prescaler=0.
- Boundary: load_val=200 with rollover_val=10, up, wrap. Required: count 200..255, 0, ..., 10, then wrap to 0 with exactly one wrap_pulse. Also, n_rst asserted mid-count clears all outputs with no clk edge.
